fifo_ddr_burst_reader: RTL and testbench

Read-side engine for the 128-bit video FIFOs in the DDR/HDMI loop path. It watches the FIFO read water level, drains one fixed-length burst of FIFO words at a time, and presents each burst as a command plus a valid/ready write-data stream toward the DDR write port. It sits between the read port of the input-side FIFO and the DDR controller's write channel. It generates frame-linear addresses that wrap at a programmable frame size.

---
 rtl/fifo_ddr_burst_reader.sv | 176 +++++++++++++++++
 tb/tb_fifo_ddr_burst_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ddr_burst_reader.sv
// Drains fixed-length bursts from a video FIFO into a DDR write command plus a valid/ready beat stream.
// Command 1 cycle after threshold, first beat 3 cycles after command accept; FIFO reads throttle so the 4-entry skid buffer cannot fill.
module fifo_ddr_burst_reader #(
   parameter int c_DATA_WIDTH   = 128,
   parameter int c_LEVEL_WIDTH  = 9,
   parameter int c_ADDR_WIDTH   = 28,
   parameter int c_BASE_ADDR    = 0,
   parameter int c_BURST_LEN    = 16,
   parameter int c_FRAME_BURSTS = 16200
) (
   input  logic                      rd_clk,
   input  logic                      rd_rst,
   output logic                      fifo_rd_en,
   input  logic [c_DATA_WIDTH-1:0]   fifo_rd_data,
   input  logic                      fifo_rd_empty,
   input  logic [c_LEVEL_WIDTH:0]    fifo_rd_water_level,
   input  logic                      frame_start,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [c_ADDR_WIDTH-1:0]   cmd_addr,
   output logic [7:0]                cmd_len,
   output logic                      wdata_valid,
   input  logic                      wdata_ready,
   output logic [c_DATA_WIDTH-1:0]   wdata,
   output logic                      wdata_last,
   output logic                      busy,
   output logic                      frame_done
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   localparam int c_LW  = c_LEVEL_WIDTH + 1;
   localparam int c_BCW = $clog2(c_FRAME_BURSTS + 1);
   localparam logic [c_LW-1:0]         c_THRESHOLD  = c_LW'(c_BURST_LEN);
   localparam logic [c_ADDR_WIDTH-1:0] c_BASE       = c_ADDR_WIDTH'(c_BASE_ADDR);
   localparam logic [c_ADDR_WIDTH-1:0] c_STEP       = c_ADDR_WIDTH'(c_BURST_LEN * c_DATA_WIDTH / 8);
   localparam logic [8:0]              c_BLEN       = 9'(c_BURST_LEN);
   localparam logic [8:0]              c_BLAST      = 9'(c_BURST_LEN - 1);
   localparam logic [c_BCW-1:0]        c_LAST_BURST = c_BCW'(c_FRAME_BURSTS - 1);

   state_t                    state_q, state_d;
   logic                      cmd_valid_q, cmd_valid_d;
   logic [c_ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
   logic [c_BCW-1:0]          burst_cnt_q, burst_cnt_d;
   logic                      start_pend_q, start_pend_d;
   logic [8:0]                rd_issued_q, rd_issued_d;
   logic [8:0]                beats_q, beats_d;
   logic                      rd_vld_q, rd_vld_d;
   logic [c_DATA_WIDTH-1:0]   skid_dat_q [0:3];
   logic [c_DATA_WIDTH-1:0]   skid_dat_d [0:3];
   logic [2:0]                skid_cnt_q, skid_cnt_d;
   logic                      wdata_valid_q, wdata_valid_d;
   logic                      wdata_last_q, wdata_last_d;
   logic                      busy_q, busy_d;

   logic                      rd_en;
   logic                      pop;
   logic                      last_acc;
   logic                      wrap;
   logic [2:0]                cnt_tmp;

   always_comb begin
      // At most two words may be held or returning when a new read is launched.
      rd_en    = (state_q == DATA) && (rd_issued_q < c_BLEN) && !fifo_rd_empty
                 && ((skid_cnt_q + {2'b0, rd_vld_q}) <= 3'd2);
      pop      = wdata_valid_q && wdata_ready;
      last_acc = pop && wdata_last_q;
      wrap     = last_acc && (burst_cnt_q == c_LAST_BURST);

      state_d      = state_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_addr_d   = cmd_addr_q;
      burst_cnt_d  = burst_cnt_q;
      start_pend_d = start_pend_q;
      rd_issued_d  = rd_en ? rd_issued_q + 9'd1 : rd_issued_q;
      beats_d      = pop ? beats_q + 9'd1 : beats_q;
      rd_vld_d     = rd_en;

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               cmd_addr_d  = c_BASE;
               burst_cnt_d = '0;
            end
            if (fifo_rd_water_level >= c_THRESHOLD) begin
               state_d     = CMD;
               cmd_valid_d = 1'b1;
            end
         end
         CMD: begin
            if (frame_start) start_pend_d = 1'b1;
            if (cmd_ready) begin
               state_d     = DATA;
               cmd_valid_d = 1'b0;
            end
         end
         DATA: begin
            if (frame_start) start_pend_d = 1'b1;
            if (last_acc) begin
               state_d      = IDLE;
               rd_issued_d  = '0;
               beats_d      = '0;
               start_pend_d = 1'b0;
               // A restart request landing on the completing beat still takes effect now.
               if (wrap || start_pend_q || frame_start) begin
                  cmd_addr_d  = c_BASE;
                  burst_cnt_d = '0;
               end else begin
                  cmd_addr_d  = cmd_addr_q + c_STEP;
                  burst_cnt_d = burst_cnt_q + c_BCW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Shift-register skid buffer: entry 0 is always the head, so wdata is a flop output.
      skid_dat_d = skid_dat_q;
      cnt_tmp    = skid_cnt_q;
      if (pop) begin
         for (int i = 0; i < 3; i++) skid_dat_d[i] = skid_dat_q[i+1];
         cnt_tmp = skid_cnt_q - 3'd1;
      end
      if (rd_vld_q) begin
         skid_dat_d[cnt_tmp[1:0]] = fifo_rd_data;
         cnt_tmp = cnt_tmp + 3'd1;
      end
      skid_cnt_d    = cnt_tmp;
      wdata_valid_d = (cnt_tmp != 3'd0);
      wdata_last_d  = wdata_valid_d && (beats_d == c_BLAST);
      busy_d        = (state_d != IDLE);
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q       <= IDLE;
         cmd_valid_q   <= 1'b0;
         cmd_addr_q    <= c_BASE;
         burst_cnt_q   <= '0;
         start_pend_q  <= 1'b0;
         rd_issued_q   <= '0;
         beats_q       <= '0;
         rd_vld_q      <= 1'b0;
         skid_dat_q    <= '{default: '0};
         skid_cnt_q    <= '0;
         wdata_valid_q <= 1'b0;
         wdata_last_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_addr_q    <= cmd_addr_d;
         burst_cnt_q   <= burst_cnt_d;
         start_pend_q  <= start_pend_d;
         rd_issued_q   <= rd_issued_d;
         beats_q       <= beats_d;
         rd_vld_q      <= rd_vld_d;
         skid_dat_q    <= skid_dat_d;
         skid_cnt_q    <= skid_cnt_d;
         wdata_valid_q <= wdata_valid_d;
         wdata_last_q  <= wdata_last_d;
         busy_q        <= busy_d;
      end
   end

   assign fifo_rd_en  = rd_en;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_addr    = cmd_addr_q;
   assign cmd_len     = 8'(c_BURST_LEN - 1);
   assign wdata_valid = wdata_valid_q;
   assign wdata       = skid_dat_q[0];
   assign wdata_last  = wdata_last_q;
   assign busy        = busy_q;
   assign frame_done  = wrap;

endmodule

// File: tb/tb_fifo_ddr_burst_reader.sv
// Bench for fifo_ddr_burst_reader: queue-based FIFO model, in-order beat scoreboard and a frame-address model,
// driven by a vector table, directed corner sequences and a randomized phase.
module tb_fifo_ddr_burst_reader;

   localparam int BL = 16;
   localparam int FB = 3;

   logic          rd_clk = 1'b0;
   logic          rd_rst;
   logic          fifo_rd_en;
   logic [127:0]  fifo_rd_data;
   logic          fifo_rd_empty;
   logic [9:0]    fifo_rd_water_level;
   logic          frame_start;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [27:0]   cmd_addr;
   logic [7:0]    cmd_len;
   logic          wdata_valid;
   logic          wdata_ready;
   logic [127:0]  wdata;
   logic          wdata_last;
   logic          busy;
   logic          frame_done;

   fifo_ddr_burst_reader #(.c_FRAME_BURSTS(FB)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
      .fifo_rd_water_level(fifo_rd_water_level), .frame_start(frame_start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wdata_last(wdata_last),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 rd_clk = ~rd_clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [127:0] fifo_q[$];
   logic [127:0] exp_q[$];
   int  next_word = 0;
   int  cyc = 0, outstanding = 0, reads_in_burst = 0, beat_in_burst = 0;
   int  bursts_done = 0, total_beats = 0, fd_count = 0, fd_beat = 0, last_count = 0;
   int  hs_cyc = 0, last_acc_cyc = 0, rise_cyc = 0;
   int  m_burst = 0;
   bit  m_pending = 0, in_burst = 0, prev_cv = 0, hold_pend = 0, hold_last = 0;
   logic [127:0] hold_dat;
   logic [27:0]  last_cmd_addr = '0;

   typedef struct {
      int add;
      bit crdy;
      bit e_cv;
      bit e_busy;
      bit e_rden;
      bit e_wv;
   } vec_t;
   vec_t vecs[8];

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sync_fifo();
      fifo_rd_water_level = 10'(fifo_q.size());
      fifo_rd_empty       = (fifo_q.size() == 0);
   endtask

   task automatic push_words(int n, bit rnd);
      logic [127:0] w;
      for (int i = 0; i < n; i++) begin
         w = rnd ? {$urandom, $urandom, $urandom, 32'(next_word)} : 128'(next_word);
         fifo_q.push_back(w);
         exp_q.push_back(w);
         next_word++;
      end
      sync_fifo();
   endtask

   // One clock: sample outputs mid-cycle, update the reference model, then apply FIFO read effects.
   task automatic tick();
      bit rd, acc, cacc, fs, done_now, exp_fd;
      logic [127:0] e;
      @(negedge rd_clk);
      cyc++;
      rd = fifo_rd_en; acc = wdata_valid && wdata_ready; cacc = cmd_valid && cmd_ready;
      fs = frame_start; done_now = 0;
      if (rd_rst) begin
         if (rd) outstanding++;
         for (int i = 0; i < outstanding; i++) if (exp_q.size() > 0) e = exp_q.pop_front();
         outstanding = 0; reads_in_burst = 0; beat_in_burst = 0;
         m_burst = 0; m_pending = 0; in_burst = 0; hold_pend = 0; prev_cv = 0;
      end else begin
         if (cmd_valid) in_burst = 1;
         if (cmd_valid && !prev_cv) rise_cyc = cyc;
         prev_cv = cmd_valid;
         check("busy", busy, in_burst);
         if (hold_pend) begin
            check("hold_valid", wdata_valid, 1);
            check("hold_data", wdata, hold_dat);
            check("hold_last", wdata_last, hold_last);
         end
         hold_pend = wdata_valid && !wdata_ready; hold_dat = wdata; hold_last = wdata_last;
         if (cacc) begin
            check("cmd_addr", cmd_addr, 128'(m_burst * 256));
            check("cmd_len", cmd_len, BL - 1);
            last_cmd_addr = cmd_addr; hs_cyc = cyc; reads_in_burst = 0; beat_in_burst = 0;
         end
         if (rd) begin
            check("rd_en_when_empty", fifo_q.size() != 0, 1);
            reads_in_burst++; outstanding++;
         end
         check("skid_occupancy_le4", outstanding <= 4, 1);
         if (acc) begin
            if (exp_q.size() == 0) check("wdata_unexpected", 1, 0);
            else begin e = exp_q.pop_front(); check("wdata", wdata, e); end
            check("wdata_last", wdata_last, beat_in_burst == BL - 1);
            outstanding--; beat_in_burst++; total_beats++;
            if (wdata_last) last_count++;
            if (beat_in_burst == BL) done_now = 1;
         end
         exp_fd = done_now && (m_burst == FB - 1);
         check("frame_done", frame_done, exp_fd);
         if (frame_done) begin fd_count++; fd_beat = total_beats; end
         if (done_now) begin
            check("reads_per_burst", reads_in_burst, BL);
            if (m_pending || fs || m_burst == FB - 1) m_burst = 0; else m_burst++;
            m_pending = 0; in_burst = 0; beat_in_burst = 0;
            bursts_done++; last_acc_cyc = cyc;
         end else if (fs) begin
            if (in_burst) m_pending = 1; else m_burst = 0;
         end
      end
      @(posedge rd_clk); #1;
      if (rd && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      sync_fifo();
   endtask

   task automatic wait_bursts(int target, int budget);
      int n = 0;
      while (bursts_done < target && n < budget) begin tick(); n++; end
      check("wait_bursts_timeout", bursts_done >= target, 1);
   endtask

   task automatic wait_beats(int target, int budget);
      int n = 0;
      while (total_beats < target && n < budget) begin tick(); n++; end
      check("wait_beats_timeout", total_beats >= target, 1);
   endtask

   task automatic check_reset_vals(string tag);
      check({tag, "_rd_en"}, fifo_rd_en, 0);
      check({tag, "_cmd_valid"}, cmd_valid, 0);
      check({tag, "_cmd_addr"}, cmd_addr, 0);
      check({tag, "_cmd_len"}, cmd_len, BL - 1);
      check({tag, "_wdata_valid"}, wdata_valid, 0);
      check({tag, "_wdata"}, wdata, 0);
      check({tag, "_wdata_last"}, wdata_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int l2;
      vecs[0] = '{0,  0, 0, 0, 0, 0};
      vecs[1] = '{15, 0, 0, 0, 0, 0};
      vecs[2] = '{0,  0, 0, 0, 0, 0};
      vecs[3] = '{1,  0, 1, 1, 0, 0};
      vecs[4] = '{0,  0, 1, 1, 0, 0};
      vecs[5] = '{0,  1, 0, 1, 1, 0};
      vecs[6] = '{0,  1, 0, 1, 1, 0};
      vecs[7] = '{0,  1, 0, 1, 1, 1};

      rd_rst = 1; frame_start = 0; cmd_ready = 0; wdata_ready = 1; fifo_rd_data = '0;
      sync_fifo();
      repeat (3) tick();
      rd_rst = 0;
      check_reset_vals("reset");

      // Threshold, command hold and first-read/first-beat latency.
      for (int i = 0; i < 8; i++) begin
         push_words(vecs[i].add, 0);
         cmd_ready = vecs[i].crdy;
         tick();
         check($sformatf("vec%0d_cmd_valid", i), cmd_valid, vecs[i].e_cv);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
         check($sformatf("vec%0d_rd_en", i), fifo_rd_en, vecs[i].e_rden);
         check($sformatf("vec%0d_wdata_valid", i), wdata_valid, vecs[i].e_wv);
         if (vecs[i].e_cv) check($sformatf("vec%0d_cmd_addr", i), cmd_addr, 0);
      end
      check("first_beat_data", wdata, 0);
      wait_bursts(1, 100);
      check("burst_latency", last_acc_cyc - hs_cyc, BL + 2);

      // Back-to-back bursts through a frame wrap.
      push_words(32, 0);
      wait_bursts(2, 100);
      check("two_bursts_beats", total_beats, 32);
      check("two_bursts_lasts", last_count, 2);
      check("second_cmd_addr", last_cmd_addr, 28'h100);
      check("no_frame_done_yet", fd_count, 0);
      l2 = last_acc_cyc;
      wait_bursts(3, 100);
      check("inter_burst_gap", rise_cyc - l2, 2);
      check("third_cmd_addr", last_cmd_addr, 28'h200);
      check("frame_done_count", fd_count, 1);
      check("frame_done_beat", fd_beat, 48);

      // Random write backpressure over one burst; address wraps to base.
      push_words(16, 1);
      begin
         int n = 0;
         while (bursts_done < 4 && n < 400) begin
            wdata_ready = ($urandom_range(0, 1) == 1);
            tick(); n++;
         end
      end
      wdata_ready = 1;
      check("random_ready_done", bursts_done, 4);
      check("wrapped_cmd_addr", last_cmd_addr, 28'h000);
      check("random_ready_beats", total_beats, 64);

      // frame_start in the middle of a burst at 0x100.
      push_words(16, 1);
      wait_beats(68, 100);
      frame_start = 1; tick(); frame_start = 0;
      wait_bursts(5, 100);
      check("fs_burst_addr", last_cmd_addr, 28'h100);
      push_words(16, 1);
      wait_bursts(6, 100);
      check("fs_next_addr", last_cmd_addr, 28'h000);
      check("fs_no_frame_done", fd_count, 1);

      // Reset at beat 5 of a burst at 0x100, then restart from base.
      push_words(16, 1);
      wait_beats(101, 100);
      check("pre_reset_addr", last_cmd_addr, 28'h100);
      wdata_ready = 0; rd_rst = 1;
      tick();
      rd_rst = 0; wdata_ready = 1;
      check_reset_vals("midrst");
      push_words(16, 1);
      wait_bursts(7, 200);
      check("post_reset_addr", last_cmd_addr, 28'h000);

      // Randomized traffic with backpressure and frame restarts.
      for (int i = 0; i < 3000; i++) begin
         if (fifo_q.size() < 100 && $urandom_range(0, 3) == 0) push_words($urandom_range(1, 8), 1);
         wdata_ready = ($urandom_range(0, 3) != 0);
         cmd_ready   = ($urandom_range(0, 1) == 1);
         frame_start = ($urandom_range(0, 63) == 0);
         tick();
      end
      frame_start = 0; wdata_ready = 1; cmd_ready = 1;
      repeat (300) tick();
      check("drain_idle", busy, 0);
      check("drain_outstanding", outstanding, 0);
      check("drain_no_loss", exp_q.size(), fifo_q.size());

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
